// File: rtl/mul_share_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_pkg
// Shared definitions for the multiplier-sharing scheduler:
//   - default parameter values (operand width, requester count, latency, depth)
//   - rsp_entry_t : layout of one response entry {id, product} at default widths
//   - clog2       : ceiling log2 used to size IDs, pointers and counters
// No ports (package).
// -----------------------------------------------------------------------------
package mul_share_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_NREQ        = 4;
    localparam int DEF_IDW         = 2;
    localparam int DEF_MUL_LATENCY = 3;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef struct packed {
        logic [DEF_IDW-1:0]     id;
        logic [2*DEF_WIDTH-1:0] y;
    } rsp_entry_t;

    // Ceiling log2, never less than 1 so the result is always a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((32'd1 << i) < value) ? (i + 1) : r;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// -----------------------------------------------------------------------------
// mul_rsp_fifo
// First-word-fall-through FIFO holding scheduler responses.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset (empties the FIFO)
//   i_push        : write i_push_data this cycle
//   i_push_data   : entry to write (EW bits)
//   i_pop         : consume the head entry (ignored when empty)
//   o_head        : head entry, valid whenever o_empty is low
//   o_empty       : no entries stored
//   o_count       : number of entries stored
// Simultaneous push and pop are allowed in any state; the caller guarantees
// that a push into a full FIFO is always accompanied by a pop.
// -----------------------------------------------------------------------------
module mul_rsp_fifo
    import mul_share_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int EW    = DEF_IDW + 2 * DEF_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [EW-1:0]                 i_push_data,
    input  logic                          i_pop,
    output logic [EW-1:0]                 o_head,
    output logic                          o_empty,
    output logic [clog2(DEPTH + 1)-1:0]   o_count
);

    localparam int PTRW = clog2(DEPTH);
    localparam int CNTW = clog2(DEPTH + 1);

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            w_pop;

    assign w_pop   = i_pop & (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array: data only, no reset needed since r_count gates validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTRW'(DEPTH - 1)) ? '0 : r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTRW'(DEPTH - 1)) ? '0 : r_rd_ptr + PTRW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// -----------------------------------------------------------------------------
// mul_share_sched
// Shares one external fixed-latency pipelined multiplier between NREQ
// requesters. Round-robin arbitration, credit-gated issue (a result slot is
// reserved in the response FIFO before an operation is issued, so results are
// never dropped), requester-ID tag pipe matched to the multiplier latency, and
// a FWFT response FIFO on a valid/ready channel.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (at most one ready bit high)
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a/mul_b         : operands to the multiplier (0 when not issuing)
//   mul_y               : multiplier product, MUL_LATENCY cycles after issue
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_y        : owning requester and unsigned 2*WIDTH product
// Optional (macro MUL_SHARE_SCHED_STATS_EN):
//   stat_issued         : wrapping count of issued operations
//   stat_stall          : wrapping count of cycles with a request but no credit
// -----------------------------------------------------------------------------
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NREQ        = DEF_NREQ,
    parameter int IDW         = DEF_IDW,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_y
`ifdef MUL_SHARE_SCHED_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_stall
`endif
);

    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int EW = IDW + 2 * WIDTH;

    if (NREQ < 2) begin : g_chk_nreq
        $error("mul_share_sched: NREQ must be at least 2");
    end
    if (IDW != clog2(NREQ)) begin : g_chk_idw
        $error("mul_share_sched: IDW must equal clog2(NREQ)");
    end
    if (FIFO_DEPTH < MUL_LATENCY + 1) begin : g_chk_depth
        $error("mul_share_sched: FIFO_DEPTH must be at least MUL_LATENCY+1");
    end

    logic [IDW-1:0]  r_rr_ptr;
    logic [CW-1:0]   r_credits;
    logic            r_tag_vld [MUL_LATENCY];
    logic [IDW-1:0]  r_tag_id  [MUL_LATENCY];

    logic [IDW-1:0]  w_grant;
    logic            w_any;
    logic            w_issue;
    logic            w_pop;
    logic            w_fifo_empty;
    logic [EW-1:0]   w_fifo_head;
    logic [CW-1:0]   w_unused_fifo_count;

    // Round-robin search starting at r_rr_ptr, wrapping at NREQ.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            logic [IDW-1:0] v_idx;
            logic           v_hit;
            v_idx   = IDW'((int'(r_rr_ptr) + k) % NREQ);
            v_hit   = ~w_any & req_valid[v_idx];
            w_grant = v_hit ? v_idx : w_grant;
            w_any   = w_any | v_hit;
        end
    end

    // Reset blocks issue so no handshake can complete while state is cleared.
    assign w_issue = w_any & (r_credits != '0) & ~rst;

    // One-hot ready to the granted requester and operand steering.
    always_comb begin
        req_ready          = '0;
        req_ready[w_grant] = w_issue;
        mul_a              = w_issue ? req_a[w_grant * WIDTH +: WIDTH] : '0;
        mul_b              = w_issue ? req_b[w_grant * WIDTH +: WIDTH] : '0;
    end

    assign rsp_valid = ~w_fifo_empty;
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_id    = w_fifo_head[EW-1 -: IDW];
    assign rsp_y     = w_fifo_head[2*WIDTH-1:0];

    // Round-robin pointer: moves past the winner on each issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Tag pipe mirroring the multiplier pipeline; clearing it on reset is what
    // discards in-flight products, since the multiplier itself is not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MUL_LATENCY; s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_id[s]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_grant;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    // Credits = free FIFO slots not yet reserved by in-flight operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CW'(FIFO_DEPTH);
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

`ifdef MUL_SHARE_SCHED_STATS_EN
    // Issue and credit-starvation counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= 32'd0;
            stat_stall  <= 32'd0;
        end else begin
            stat_issued <= w_issue ? stat_issued + 32'd1 : stat_issued;
            stat_stall  <= (w_any && (r_credits == '0)) ? stat_stall + 32'd1 : stat_stall;
        end
    end
`endif

    mul_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .EW    (EW)
    ) u_rsp_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (r_tag_vld[MUL_LATENCY-1]),
        .i_push_data ({r_tag_id[MUL_LATENCY-1], mul_y}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_unused_fifo_count)
    );

endmodule

// File: tb/tb_mul_share_sched.sv
// -----------------------------------------------------------------------------
// tb_mul_share_sched
// Directed-vector bench with a response scoreboard. A behavioural 3-stage
// multiplier (no reset) is attached to mul_a/mul_b/mul_y. Expected responses
// are queued as operations are issued; a negedge monitor pops and compares
// every response the DUT hands over.
// -----------------------------------------------------------------------------
module tb_mul_share_sched;
    import mul_share_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int L  = 3;
    localparam int D  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [2*W-1:0]   rsp_y;
`ifdef MUL_SHARE_SCHED_STATS_EN
    logic [31:0]      stat_issued;
    logic [31:0]      stat_stall;
`endif

    mul_share_sched #(
        .WIDTH(W), .NREQ(N), .IDW(IW), .MUL_LATENCY(L), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y)
`ifdef MUL_SHARE_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: L register stages, first stage samples operands.
    logic [2*W-1:0] m_pipe [L];
    always @(posedge clk) begin
        m_pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
        for (int s = 1; s < L; s++) m_pipe[s] <= m_pipe[s-1];
    end
    assign mul_y = m_pipe[L-1];

    int         n_checks = 0;
    int         n_errors = 0;
    rsp_entry_t q_exp[$];
    rsp_entry_t mon_e;
    int         issues;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    task automatic expect_rsp(input int id, input logic [63:0] y);
        rsp_entry_t t;
        t.id = IW'(id);
        t.y  = y;
        q_exp.push_back(t);
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            tick();
            done = (q_exp.size() == 0) && !rsp_valid;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q_exp.size());
        end
    endtask

    // Scoreboard monitor: compare every accepted response with the queue head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got id %0d y 0x%0h, expected none", rsp_id, rsp_y);
            end else begin
                mon_e = q_exp.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                chk("rsp_y", rsp_y, mon_e.y);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Ready pattern expected while all four requesters stay valid.
    logic [3:0] rr_ready [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
    int         rr_id    [6] = '{0, 1, 2, 3, 0, 0};
    logic [63:0] rr_y    [6] = '{64'd2, 64'd4, 64'd6, 64'd8, 64'd0, 64'd2};

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

        // Reset: outputs quiet even with every requester asking.
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_op(i, 32'd9, 32'd9);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single op with latency check.
        rsp_ready = 1'b1;
        set_op(0, 32'd3, 32'd5);
        req_valid = 4'b0001;
        #1;
        chk("s1_ready", 64'(req_ready), 64'h1);
        chk("s1_mul_a", 64'(mul_a), 64'd3);
        chk("s1_mul_b", 64'(mul_b), 64'd5);
        expect_rsp(0, 64'd15);
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            chk("s1_lat_early", 64'(rsp_valid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("s1_lat_exact", 64'(rsp_valid), 64'd1);
        wait_drain(20);

        // Max operands from requester 3 (also leaves rr_ptr at 0).
        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b1000;
        #1;
        chk("s2_ready", 64'(req_ready), 64'h8);
        expect_rsp(3, 64'hFFFF_FFFE_0000_0001);
        tick();
        req_valid = '0;
        wait_drain(20);

        // Round-robin with everyone valid; credits run dry after four issues.
        for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd2);
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("s3_rr_ready", 64'(req_ready), 64'(rr_ready[c]));
            if (rr_ready[c] != 4'b0000) expect_rsp(rr_id[c], rr_y[c]);
            tick();
        end
        req_valid = '0;
        wait_drain(30);

        // Backpressure: exactly D issues, then one more per freed slot.
        rsp_ready = 1'b0;
        set_op(1, 32'd7, 32'd9);
        req_valid = 4'b0010;
        issues = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("s4_fill_ready", 64'(req_ready), (c < D) ? 64'h2 : 64'h0);
            if (|(req_valid & req_ready)) begin
                issues++;
                expect_rsp(1, 64'd63);
            end
            tick();
        end
        chk("s4_issues_full", 64'(issues), 64'(D));
        rsp_ready = 1'b1;
        #1;
        chk("s4_ready_at_pop", 64'(req_ready), 64'h0);
        tick();
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("s4_refill_ready", 64'(req_ready), (c == 0) ? 64'h2 : 64'h0);
            if (|(req_valid & req_ready)) begin
                issues++;
                expect_rsp(1, 64'd63);
            end
            tick();
        end
        chk("s4_issues_after_pop", 64'(issues), 64'(D + 1));
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain(30);

        // Reset with two operations in flight.
        set_op(0, 32'd4, 32'd4);
        req_valid = 4'b0001;
        #1;
        chk("s5_ready_a", 64'(req_ready), 64'h1);
        tick();
        #1;
        chk("s5_ready_b", 64'(req_ready), 64'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("s5_ready_in_rst", 64'(req_ready), 64'h0);
        chk("s5_mul_a_in_rst", 64'(mul_a), 64'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("s5_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        rsp_ready = 1'b0;
        set_op(2, 32'd6, 32'd11);
        req_valid = 4'b0100;
        issues = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("s5_credit_ready", 64'(req_ready), (c < D) ? 64'h4 : 64'h0);
            if (|(req_valid & req_ready)) begin
                issues++;
                expect_rsp(2, 64'd66);
            end
            tick();
        end
        chk("s5_credits_restored", 64'(issues), 64'(D));
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain(30);

`ifdef MUL_SHARE_SCHED_STATS_EN
        // Statistics over ten backpressured cycles.
        rst = 1'b1;
        rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
        set_op(1, 32'd7, 32'd9);
        req_valid = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (|(req_valid & req_ready)) expect_rsp(1, 64'd63);
            tick();
        end
        chk("stat_issued", 64'(stat_issued), 64'(D));
        chk("stat_stall", 64'(stat_stall), 64'(10 - D));
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain(30);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
